// File: rtl/hatch_ctrl.sv
// Incubation sequencer: walks the display stage number 0..LAST_STAGE on a 1 s
// time base, pausing on abnormal temperature and failing if the fault persists.
module hatch_ctrl #(
    parameter int CLK_DIV    = 1000,
    parameter int STAGE_SEC  = 5,
    parameter int COLD_LIMIT = 10,
    parameter int LAST_STAGE = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       st,
    input  logic       temp,
    output logic [3:0] num,
    output logic [7:0] stage_sec,
    output logic [7:0] fault_sec,
    output logic       run,
    output logic       adv,
    output logic       hatched,
    output logic       failed,
    output logic [2:0] dbg_state
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INCUBATE,
        S_PAUSE,
        S_HATCHED,
        S_FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    num_q, num_d;
    logic [7:0]    stage_q, stage_d;
    logic [7:0]    fault_q, fault_d;
    logic          run_q, adv_q, adv_d, hatched_q, failed_q;
    logic          tick;

    assign tick = (presc_q == PW'(CLK_DIV - 1));

    always_comb begin
        state_d = state_q;
        presc_d = '0;
        num_d   = num_q;
        stage_d = stage_q;
        fault_d = fault_q;
        adv_d   = 1'b0;
        if (!st) begin
            state_d = S_IDLE;
            num_d   = '0;
            stage_d = '0;
            fault_d = '0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_INCUBATE;
                S_INCUBATE: begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    // Abnormal temperature wins over a coincident tick.
                    if (temp) begin
                        state_d = S_PAUSE;
                    end else if (tick) begin
                        if (stage_q == 8'(STAGE_SEC - 1)) begin
                            stage_d = '0;
                            num_d   = num_q + 4'd1;
                            adv_d   = 1'b1;
                            if (num_q + 4'd1 == 4'(LAST_STAGE)) begin
                                state_d = S_HATCHED;
                                presc_d = '0;
                            end
                        end else if (stage_q != 8'hFF) begin
                            stage_d = stage_q + 8'd1;
                        end
                    end
                end
                S_PAUSE: begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick && fault_q != 8'hFF) fault_d = fault_q + 8'd1;
                    // The tick is counted before a temperature recovery is honoured.
                    if (tick && fault_q == 8'(COLD_LIMIT - 1)) begin
                        state_d = S_FAIL;
                        presc_d = '0;
                    end else if (!temp) begin
                        state_d = S_INCUBATE;
                        fault_d = '0;
                    end
                end
                S_HATCHED, S_FAIL: state_d = state_q;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            num_q     <= '0;
            stage_q   <= '0;
            fault_q   <= '0;
            run_q     <= 1'b0;
            adv_q     <= 1'b0;
            hatched_q <= 1'b0;
            failed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            num_q     <= num_d;
            stage_q   <= stage_d;
            fault_q   <= fault_d;
            run_q     <= (state_d == S_INCUBATE);
            adv_q     <= adv_d;
            hatched_q <= (state_d == S_HATCHED);
            failed_q  <= (state_d == S_FAIL);
        end
    end

    assign num       = num_q;
    assign stage_sec = stage_q;
    assign fault_sec = fault_q;
    assign run       = run_q;
    assign adv       = adv_q;
    assign hatched   = hatched_q;
    assign failed    = failed_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_hatch_ctrl.sv
// Bench for hatch_ctrl: directed scenarios plus random st/temp traffic, every
// cycle scored against a seconds-counting reference model.
module tb_hatch_ctrl;

    localparam int CD   = 4;
    localparam int SS   = 2;
    localparam int CL   = 3;
    localparam int LAST = 11;

    localparam int M_IDLE  = 0;
    localparam int M_INC   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_HATCH = 3;
    localparam int M_FAIL  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       st = 1'b0;
    logic       temp = 1'b0;
    logic [3:0] num;
    logic [7:0] stage_sec;
    logic [7:0] fault_sec;
    logic       run, adv, hatched, failed;
    logic [2:0] dbg_state;

    hatch_ctrl #(
        .CLK_DIV(CD), .STAGE_SEC(SS), .COLD_LIMIT(CL), .LAST_STAGE(LAST)
    ) dut (
        .clk(clk), .rst(rst), .st(st), .temp(temp),
        .num(num), .stage_sec(stage_sec), .fault_sec(fault_sec),
        .run(run), .adv(adv), .hatched(hatched), .failed(failed),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    logic [23:0] exp_q[$];

    // Reference model: total good seconds, consecutive fault seconds, tick phase.
    int m_mode = M_IDLE;
    int m_good = 0;
    int m_fault = 0;
    int m_phase = 0;
    bit m_adv = 1'b0;

    function automatic logic [23:0] dut_pack();
        return {num, stage_sec, fault_sec, run, adv, hatched, failed};
    endfunction

    function automatic logic [23:0] model_pack();
        logic [3:0] n;
        logic [7:0] s;
        logic [7:0] f;
        n = 4'(m_good / SS);
        s = 8'(m_good % SS);
        f = 8'(m_fault);
        return {n, s, f, (m_mode == M_INC), m_adv, (m_mode == M_HATCH), (m_mode == M_FAIL)};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_good = 0; m_fault = 0; m_phase = 0; m_adv = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic t);
        bit tk;
        tk = (m_phase == CD - 1);
        m_adv = 1'b0;
        if (!s) begin
            model_reset();
        end else begin
            case (m_mode)
                M_IDLE: begin m_mode = M_INC; m_phase = 0; end
                M_INC: begin
                    m_phase = (m_phase + 1) % CD;
                    if (t) m_mode = M_PAUSE;
                    else if (tk) begin
                        m_good++;
                        if (m_good % SS == 0) m_adv = 1'b1;
                        if (m_good / SS == LAST) begin m_mode = M_HATCH; m_phase = 0; end
                    end
                end
                M_PAUSE: begin
                    m_phase = (m_phase + 1) % CD;
                    if (tk && m_fault < 255) m_fault++;
                    if (tk && m_fault == CL) begin m_mode = M_FAIL; m_phase = 0; end
                    else if (!t) begin m_mode = M_INC; m_fault = 0; end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_vec(input string name, input logic [23:0] act, input logic [23:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s @%0t: actual num=%0d stage_sec=%0d fault_sec=%0d run/adv/hatched/failed=%b, required num=%0d stage_sec=%0d fault_sec=%0d run/adv/hatched/failed=%b",
                     name, $time, act[23:20], act[19:12], act[11:4], act[3:0],
                     req[23:20], req[19:12], req[11:4], req[3:0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fails++;
            $display("FAIL %s @%0t: actual %0d, required %0d", name, $time, act, req);
        end
    endtask

    task automatic monitor_loop();
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_vec("scoreboard", dut_pack(), e);
            end
        end
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic cycle(input logic s, input logic t);
        st = s;
        temp = t;
        model_step(s, t);
        @(posedge clk);
        exp_q.push_back(model_pack());
        #1;
    endtask

    task automatic cycles(input logic s, input logic t, input int n);
        for (int i = 0; i < n; i++) cycle(s, t);
    endtask

    // Reset is asserted mid-cycle, after that cycle's expectation was consumed.
    task automatic do_reset();
        #6;
        rst = 1'b1;
        #1;
        check_vec("async_reset", dut_pack(), 24'h0);
        model_reset();
        @(posedge clk);
        exp_q.push_back(24'h0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int t_run;
        int t_hatch;
        logic s_r;
        logic t_r;
        fork
            monitor_loop();
        join_none
        #1;
        do_reset();

        // Fault-free run: hatch 88 cycles after run rises.
        t_run = -1;
        t_hatch = -1;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 1'b0);
            if (run && t_run < 0) t_run = i;
            if (hatched && t_hatch < 0) t_hatch = i;
        end
        check_int("hatch_latency", t_hatch - t_run, LAST * SS * CD);
        check_int("hatch_num", int'(num), LAST);
        cycle(1'b0, 1'b0);
        check_int("hatched_cleared", int'(hatched), 0);

        // Pause mid-stage for two ticks, then recover and finish.
        cycles(1'b1, 1'b0, 6);
        check_int("pre_pause_stage_sec", int'(stage_sec), 1);
        cycles(1'b1, 1'b1, 8);
        check_int("pause_fault_sec", int'(fault_sec), 2);
        cycles(1'b1, 1'b0, 110);
        cycle(1'b0, 1'b0);

        // Persistent fault ends in FAIL.
        cycle(1'b1, 1'b0);
        cycles(1'b1, 1'b1, 16);
        check_int("fail_flags", int'({failed, run}), 2);
        cycle(1'b0, 1'b1);
        check_vec("fail_to_idle", dut_pack(), 24'h0);

        // Tick coincides with temp rising.
        cycles(1'b1, 1'b0, 4);
        cycle(1'b1, 1'b1);
        check_int("tick_temp_adv", int'(adv), 0);
        check_int("tick_temp_stage_sec", int'(stage_sec), 0);
        check_int("tick_temp_run", int'(run), 0);
        cycles(1'b1, 1'b0, 3);
        cycle(1'b0, 1'b0);

        // Drop st at num=5, then restart.
        cycles(1'b1, 1'b0, 41);
        check_int("num_before_drop", int'(num), 5);
        cycle(1'b0, 1'b0);
        check_int("num_after_drop", int'(num), 0);
        cycles(1'b1, 1'b0, 12);

        // Asynchronous reset during PAUSE.
        cycles(1'b1, 1'b1, 3);
        st = 1'b1;
        do_reset();
        cycle(1'b1, 1'b0);
        check_int("run_after_reset", int'(run), 1);

        // Random st/temp traffic.
        s_r = 1'b1;
        t_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (s_r && $urandom_range(0, 299) == 0) s_r = 1'b0;
            else if (!s_r && $urandom_range(0, 2) == 0) s_r = 1'b1;
            if ($urandom_range(0, 9) == 0) t_r = ~t_r;
            if (m_mode == M_PAUSE && m_phase == CD - 1 && m_fault == CL - 1) t_r = 1'b1;
            cycle(s_r, t_r);
        end

        @(negedge clk);
        #1;
        check_int("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
